pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Generates per-stage enables, bubble/flush strobes and the PC redirect select from three hazard sources: load-use hazards, taken branches/jumps resolved in MEM, and a multi-cycle data-memory handshake.
- Includes a start-up state, a memory-timeout halt, and saturating stall/flush performance counters.

Parameters:
REG_ADDR_W, 5, register-index width
CNT_W, 32, performance counter width
MEM_TIMEOUT, 255, max consecutive dmem wait cycles before halt (1..2^16-1)

Ports:
clk  in  1  clock
arst  in  1  reset, asynchronous, active-high
if_id_rs1  in  REG_ADDR_W  rs1 of instruction in ID
if_id_rs2  in  REG_ADDR_W  rs2 of instruction in ID
if_id_uses_rs2  in  1  ID instruction reads rs2
id_ex_rd  in  REG_ADDR_W  destination register in EX
id_ex_memread  in  1  EX instruction is a load
ex_mem_membranch  in  1  MEM instruction is a branch
ex_mem_zero  in  1  branch condition true
ex_mem_memjump  in  1  MEM instruction is a jump
dmem_req  in  1  MEM stage accesses data memory this cycle
dmem_ready  in  1  data memory completes access this cycle
en_pc  out  1  PC register enable
en_if_id  out  1  IF/ID enable
en_id_ex  out  1  ID/EX enable
en_ex_mem  out  1  EX/MEM enable
en_mem_wb  out  1  MEM/WB enable
flush_if_id  out  1  IF/ID loads NOP on next edge
bubble_id_ex  out  1  ID/EX loads zero control fields on next edge
bubble_ex_mem  out  1  EX/MEM loads zero control fields on next edge
pc_sel  out  2  0 = pc+4, 1 = branch target, 2 = jump target
mem_err  out  1  sticky, set on dmem timeout
stall_cnt  out  CNT_W  saturating count of cycles with en_pc=0 in RUN/MEM_WAIT
flush_cnt  out  CNT_W  saturating count of redirects

Behaviour:
- Reset is asynchronous and active-high. While arst=1: state=START, all enables 0, all flush/bubble 0, pc_sel 0, mem_err 0, counters 0, wait counter 0.
- Outputs are combinational from state and current inputs, and take effect at the next clk edge. Counters, mem_err and state are registered.
- FSM states: START, RUN, MEM_WAIT, HALT.
- START: all enables 0 for exactly one cycle after reset release, then RUN.
- RUN, priority order highest first:
  - 1) Memory stall: dmem_req=1 and dmem_ready=0. All enables 0, flush/bubble 0, pc_sel 0. Next state MEM_WAIT, wait counter=1.
  - 2) Redirect: ex_mem_memjump=1, or ex_mem_membranch & ex_mem_zero=1. All enables 1. pc_sel=2 if jump, else 1 (jump wins if both). flush_if_id=1, bubble_id_ex=1, bubble_ex_mem=1. flush_cnt+1.
  - 3) Load-use: id_ex_memread=1, id_ex_rd!=0, and (id_ex_rd==if_id_rs1, or if_id_uses_rs2 and id_ex_rd==if_id_rs2). en_pc=0, en_if_id=0, en_id_ex=1 with bubble_id_ex=1, en_ex_mem=1, en_mem_wb=1. Lasts one cycle; the hazard clears naturally.
  - 4) Otherwise: all enables 1, pc_sel 0.
- MEM_WAIT:
  - dmem_ready=0: all enables 0. Wait counter +1. When the counter equals MEM_TIMEOUT: set mem_err and go to HALT.
  - dmem_ready=1: evaluate exactly as RUN rules 2-4 in the same cycle; next state RUN.
  - A redirect pending in MEM is therefore applied in the release cycle.
- HALT: all enables 0, flush/bubble 0. Held until arst.
- pc_sel is nonzero only when en_pc=1.
- stall_cnt increments on every cycle in RUN or MEM_WAIT with en_pc=0.
- Both counters saturate at all-ones and do not wrap.
- Register index 0 never triggers a load-use hazard.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state enum: START, RUN, MEM_WAIT, HALT.
  - pc_sel encodings: PCSEL_SEQ=0, PCSEL_BR=1, PCSEL_JMP=2.
- One sub-module, sat_counter (parameter CNT_W, inputs inc/clear, saturating), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset released, no hazards -> cycle 0 all enables 0 (START); cycle 1 onward all enables 1, pc_sel=0.
- id_ex_memread=1, id_ex_rd=5, if_id_rs2=5, if_id_uses_rs2=1 -> one cycle with en_pc=0, en_if_id=0, bubble_id_ex=1; stall_cnt=1. Repeat with id_ex_rd=0 -> no stall.
- ex_mem_membranch=1, ex_mem_zero=1, concurrent with a load-use hazard -> pc_sel=1, all three flush/bubble strobes=1, no stall; flush_cnt=1. Jump and branch together -> pc_sel=2.
- dmem_req=1, dmem_ready low for 3 cycles then high, with a taken jump in MEM -> 3 frozen cycles (stall_cnt=3); release cycle shows pc_sel=2 with flush strobes; state returns to RUN.
- MEM_TIMEOUT=4, dmem_ready held 0 -> mem_err=1 after 4 wait cycles, HALT with all enables 0; arst pulse mid-HALT -> mem_err=0, START.
- Assert arst mid-MEM_WAIT -> outputs go to reset values immediately without waiting for clk.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline sequencing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Controller state
    typedef enum logic [1:0] {
        START    = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    // PC source select encodings
    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_BR  = 2'd1;
    localparam logic [1:0] PCSEL_JMP = 2'd2;

    // Width of the consecutive dmem wait-cycle counter
    localparam int WAIT_W = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count reflects inc one clock after it is sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, stick at all-ones, clear has priority
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing: stage enables, bubbles/flushes and PC redirect from hazards.
// Latency: enables/strobes are combinational, act on the next clk edge; counters/state registered.
// Backpressure: dmem not ready freezes all stages; timeout halts until reset.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic                  if_id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_memread,
    input  logic                  ex_mem_membranch,
    input  logic                  ex_mem_zero,
    input  logic                  ex_mem_memjump,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  en_pc,
    output logic                  en_if_id,
    output logic                  en_id_ex,
    output logic                  en_ex_mem,
    output logic                  en_mem_wb,
    output logic                  flush_if_id,
    output logic                  bubble_id_ex,
    output logic                  bubble_ex_mem,
    output logic [1:0]            pc_sel,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              err_nxt;
    logic              load_use, redirect, mem_stall, run_active;
    logic              stall_inc, flush_inc;

    // x0 is hardwired, so a load targeting it never creates a dependency
    assign load_use  = id_ex_memread && (id_ex_rd != '0) &&
                       ((id_ex_rd == if_id_rs1) ||
                        (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));
    assign redirect  = ex_mem_memjump || (ex_mem_membranch && ex_mem_zero);
    assign mem_stall = dmem_req && !dmem_ready;
    // Cycles where normal hazard resolution applies; a MEM_WAIT release acts like RUN
    assign run_active = ((state == RUN) && !mem_stall) ||
                        ((state == MEM_WAIT) && dmem_ready);

    // State, wait counter and sticky error register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= START;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            mem_err  <= err_nxt;
        end
    end

    // Next-state logic; wait_cnt counts frozen cycles including the entry cycle
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        err_nxt   = mem_err;
        case (state)
            START: state_nxt = RUN;
            RUN: begin
                if (mem_stall) begin
                    wait_nxt = WAIT_W'(1);
                    if (TIMEOUT == WAIT_W'(1)) begin
                        state_nxt = HALT;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                    if ((wait_cnt + WAIT_W'(1)) == TIMEOUT) begin
                        state_nxt = HALT;
                        err_nxt   = 1'b1;
                    end
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = START;
        endcase
    end

    // Output decode: redirect beats load-use; frozen states drive everything low
    always_comb begin
        en_pc         = 1'b0;
        en_if_id      = 1'b0;
        en_id_ex      = 1'b0;
        en_ex_mem     = 1'b0;
        en_mem_wb     = 1'b0;
        flush_if_id   = 1'b0;
        bubble_id_ex  = 1'b0;
        bubble_ex_mem = 1'b0;
        pc_sel        = PCSEL_SEQ;
        if (run_active) begin
            en_id_ex  = 1'b1;
            en_ex_mem = 1'b1;
            en_mem_wb = 1'b1;
            if (redirect) begin
                en_pc         = 1'b1;
                en_if_id      = 1'b1;
                flush_if_id   = 1'b1;
                bubble_id_ex  = 1'b1;
                bubble_ex_mem = 1'b1;
                pc_sel        = ex_mem_memjump ? PCSEL_JMP : PCSEL_BR;
            end else if (load_use) begin
                bubble_id_ex = 1'b1;
            end else begin
                en_pc    = 1'b1;
                en_if_id = 1'b1;
            end
        end
    end

    assign stall_inc = ((state == RUN) || (state == MEM_WAIT)) && !en_pc;
    assign flush_inc = run_active && redirect;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .arst  (arst),
        .inc   (stall_inc),
        .clear (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .arst  (arst),
        .inc   (flush_inc),
        .clear (1'b0),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4.
// Latency: outputs sampled 1+ time units after the rising edge.
// Backpressure: dmem_ready driven directly by the stimulus.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        arst;
    logic [4:0]  if_id_rs1, if_id_rs2, id_ex_rd;
    logic        if_id_uses_rs2, id_ex_memread;
    logic        ex_mem_membranch, ex_mem_zero, ex_mem_memjump;
    logic        dmem_req, dmem_ready;
    logic        en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic        flush_if_id, bubble_id_ex, bubble_ex_mem;
    logic [1:0]  pc_sel;
    logic        mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    logic [4:0] en_v;
    logic [2:0] strb_v;
    assign en_v   = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb};
    assign strb_v = {flush_if_id, bubble_id_ex, bubble_ex_mem};

    pipe_hazard_ctrl #(
        .REG_ADDR_W  (5),
        .CNT_W       (32),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk              (clk),
        .arst             (arst),
        .if_id_rs1        (if_id_rs1),
        .if_id_rs2        (if_id_rs2),
        .if_id_uses_rs2   (if_id_uses_rs2),
        .id_ex_rd         (id_ex_rd),
        .id_ex_memread    (id_ex_memread),
        .ex_mem_membranch (ex_mem_membranch),
        .ex_mem_zero      (ex_mem_zero),
        .ex_mem_memjump   (ex_mem_memjump),
        .dmem_req         (dmem_req),
        .dmem_ready       (dmem_ready),
        .en_pc            (en_pc),
        .en_if_id         (en_if_id),
        .en_id_ex         (en_id_ex),
        .en_ex_mem        (en_ex_mem),
        .en_mem_wb        (en_mem_wb),
        .flush_if_id      (flush_if_id),
        .bubble_id_ex     (bubble_id_ex),
        .bubble_ex_mem    (bubble_ex_mem),
        .pc_sel           (pc_sel),
        .mem_err          (mem_err),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_id_rs1 = '0; if_id_rs2 = '0; if_id_uses_rs2 = 1'b0;
        id_ex_rd = '0; id_ex_memread = 1'b0;
        ex_mem_membranch = 1'b0; ex_mem_zero = 1'b0; ex_mem_memjump = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        arst = 1'b1;
        clear_inputs();
        tick();
        tick();

        // Reset values
        chk("rst_en", 32'(en_v), 32'h00);
        chk("rst_strb", 32'(strb_v), 32'h0);
        chk("rst_pcsel", 32'(pc_sel), 32'h0);
        chk("rst_memerr", 32'(mem_err), 32'h0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_flush", flush_cnt, 32'd0);

        // START cycle then RUN
        arst = 1'b0;
        #1 chk("start_en", 32'(en_v), 32'h00);
        tick();
        chk("run_en", 32'(en_v), 32'h1f);
        chk("run_pcsel", 32'(pc_sel), 32'h0);
        chk("start_no_stall", stall_cnt, 32'd0);

        // Load-use on rs2
        id_ex_memread = 1'b1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5; if_id_uses_rs2 = 1'b1; if_id_rs1 = 5'd3;
        #1 chk("lu_rs2_en", 32'(en_v), 32'h07);
        chk("lu_rs2_strb", 32'(strb_v), 32'h2);
        tick();
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        // rd=0 never stalls
        id_ex_rd = 5'd0; if_id_rs2 = 5'd0; if_id_rs1 = 5'd0;
        #1 chk("lu_x0_en", 32'(en_v), 32'h1f);
        // rs2 match ignored when not used
        id_ex_rd = 5'd7; if_id_rs2 = 5'd7; if_id_uses_rs2 = 1'b0; if_id_rs1 = 5'd3;
        #1 chk("lu_rs2_unused_en", 32'(en_v), 32'h1f);
        // rs1 match
        id_ex_rd = 5'd9; if_id_rs1 = 5'd9;
        #1 chk("lu_rs1_en", 32'(en_v), 32'h07);
        tick();
        chk("lu_stall_cnt2", stall_cnt, 32'd2);

        // Taken branch beats a concurrent load-use
        ex_mem_membranch = 1'b1; ex_mem_zero = 1'b1;
        id_ex_rd = 5'd5; if_id_rs1 = 5'd5;
        #1 chk("br_en", 32'(en_v), 32'h1f);
        chk("br_strb", 32'(strb_v), 32'h7);
        chk("br_pcsel", 32'(pc_sel), 32'h1);
        tick();
        chk("br_flush_cnt", flush_cnt, 32'd1);
        chk("br_no_stall", stall_cnt, 32'd2);
        // Jump wins over branch
        ex_mem_memjump = 1'b1;
        #1 chk("jmp_pcsel", 32'(pc_sel), 32'h2);
        tick();
        chk("jmp_flush_cnt", flush_cnt, 32'd2);
        // Branch not taken
        clear_inputs();
        ex_mem_membranch = 1'b1;
        #1 chk("br_nt_pcsel", 32'(pc_sel), 32'h0);
        chk("br_nt_strb", 32'(strb_v), 32'h0);

        // dmem wait for 3 cycles with a jump pending in MEM
        clear_inputs();
        dmem_req = 1'b1; ex_mem_memjump = 1'b1;
        #1 chk("mw_run_en", 32'(en_v), 32'h00);
        chk("mw_run_pcsel", 32'(pc_sel), 32'h0);
        chk("mw_run_strb", 32'(strb_v), 32'h0);
        tick();
        chk("mw_wait_en", 32'(en_v), 32'h00);
        tick();
        tick();
        dmem_ready = 1'b1;
        #1 chk("mw_rel_en", 32'(en_v), 32'h1f);
        chk("mw_rel_pcsel", 32'(pc_sel), 32'h2);
        chk("mw_rel_strb", 32'(strb_v), 32'h7);
        tick();
        chk("mw_stall_cnt", stall_cnt, 32'd5);
        chk("mw_flush_cnt", flush_cnt, 32'd3);
        // Back in RUN: an idle dmem does not freeze
        clear_inputs();
        #1 chk("mw_back_run", 32'(en_v), 32'h1f);

        // Timeout after 4 wait cycles
        dmem_req = 1'b1;
        tick();
        tick();
        tick();
        chk("to_pre_err", 32'(mem_err), 32'h0);
        tick();
        chk("to_err", 32'(mem_err), 32'h1);
        chk("to_halt_en", 32'(en_v), 32'h00);
        chk("to_stall_cnt", stall_cnt, 32'd9);
        // HALT ignores ready and redirects
        clear_inputs();
        dmem_ready = 1'b1; ex_mem_membranch = 1'b1; ex_mem_zero = 1'b1;
        #1 chk("halt_en", 32'(en_v), 32'h00);
        chk("halt_strb", 32'(strb_v), 32'h0);
        chk("halt_pcsel", 32'(pc_sel), 32'h0);
        tick();
        chk("halt_stall_hold", stall_cnt, 32'd9);
        chk("halt_flush_hold", flush_cnt, 32'd3);

        // Reset pulse in HALT
        clear_inputs();
        arst = 1'b1;
        #1 chk("halt_rst_err", 32'(mem_err), 32'h0);
        chk("halt_rst_stall", stall_cnt, 32'd0);
        chk("halt_rst_flush", flush_cnt, 32'd0);
        #1 arst = 1'b0;
        #1 chk("halt_rst_start", 32'(en_v), 32'h00);
        tick();
        chk("halt_rst_run", 32'(en_v), 32'h1f);

        // Asynchronous reset in the middle of MEM_WAIT
        dmem_req = 1'b1;
        tick();
        tick();
        chk("amw_stall_cnt", stall_cnt, 32'd2);
        #2 arst = 1'b1;
        #1 chk("amw_stall_rst", stall_cnt, 32'd0);
        chk("amw_en", 32'(en_v), 32'h00);
        dmem_req = 1'b0;
        #1 chk("amw_en_held", 32'(en_v), 32'h00);
        #1 arst = 1'b0;
        tick();
        chk("amw_run_en", 32'(en_v), 32'h1f);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
